// File: rtl/spi_pkg.sv
// Shared types and default sizing for the SPI transmit controller.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } spi_state_t;

  localparam int SPI_DATA_W  = 8;
  localparam int SPI_CLK_DIV = 4;

endpackage

// File: rtl/spi_tx_ctrl_if.sv
// Strobe, SPI pin and status bundle between the button logic and spi_tx_ctrl.
interface spi_tx_ctrl_if
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W
) ();

  logic              next_count;
  logic              start_send;
  logic              miso;
  logic              sclk;
  logic              mosi;
  logic              cs_n;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] count_value;
  logic [DATA_W-1:0] rx_data;

  modport slave (
    input  next_count, start_send, miso,
    output sclk, mosi, cs_n, busy, done, count_value, rx_data
  );

  modport master (
    output next_count, start_send, miso,
    input  sclk, mosi, cs_n, busy, done, count_value, rx_data
  );

endinterface

// File: rtl/spi_clk_gen.sv
// CLK_DIV half-period divider: registered SCLK plus one-cycle strobes that
// are high in the cycle before SCLK rises or falls.
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = SPI_CLK_DIV
) (
  input  logic clk,
  input  logic s_rst_n,
  input  logic i_en,
  input  logic i_clr,
  input  logic i_toggle_en,
  output logic o_tick,
  output logic o_rise_stb,
  output logic o_fall_stb,
  output logic o_sclk
);

  localparam int            CW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          r_sclk;

  assign o_tick     = i_en && (r_cnt == CNT_MAX);
  assign o_rise_stb = o_tick && i_toggle_en && !r_sclk;
  assign o_fall_stb = o_tick && i_toggle_en &&  r_sclk;
  assign o_sclk     = r_sclk;

  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (i_clr || !i_en) begin
      r_cnt <= '0;
      if (i_clr) r_sclk <= 1'b0;
    end else if (o_tick) begin
      r_cnt <= '0;
      if (i_toggle_en) r_sclk <= ~r_sclk;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/spi_tx_ctrl.sv
// Wrapping counter plus SPI mode-0 transmitter that sends the counter value
// and captures MISO. Define SPI_LOOPBACK_EN to receive from the internal MOSI.
module spi_tx_ctrl
  import spi_pkg::*;
#(
  parameter int DATA_W  = SPI_DATA_W,
  parameter int CLK_DIV = SPI_CLK_DIV
) (
  input  logic          clk,
  input  logic          s_rst_n,
  spi_tx_ctrl_if.slave  bus
);

  localparam int            EW         = $clog2(2*DATA_W + 1);
  localparam logic [EW-1:0] LAST_EDGE  = EW'(2*DATA_W);
  localparam logic [EW-1:0] LAST_FALL  = EW'(2*DATA_W - 1);

  spi_state_t        r_state, w_state_nxt;
  logic [DATA_W-1:0] r_count;
  logic [DATA_W-1:0] r_tx_sh, w_tx_sh_nxt;
  logic [DATA_W-1:0] r_rx_sh, w_rx_sh_nxt;
  logic [DATA_W-1:0] r_rx_data, w_rx_data_nxt;
  logic [EW-1:0]     r_edge_cnt, w_edge_cnt_nxt;
  logic              r_cs_n, w_cs_n_nxt;
  logic              r_done, w_done_nxt;
  logic              w_clk_en, w_clk_clr, w_toggle_en;
  logic              w_tick, w_rise_stb, w_fall_stb, w_sclk, w_rx_bit;

`ifdef SPI_LOOPBACK_EN
  assign w_rx_bit = r_tx_sh[DATA_W-1];
`else
  assign w_rx_bit = bus.miso;
`endif

  // SCLK keeps toggling until all 2*DATA_W edges are out, then the divider
  // only times the trailing low hold.
  assign w_clk_en    = (r_state == SETUP) || (r_state == SHIFT);
  assign w_toggle_en = w_clk_en && (r_edge_cnt != LAST_EDGE);
  assign w_clk_clr   = (r_state == IDLE) && bus.start_send;

  spi_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk         (clk),
    .s_rst_n     (s_rst_n),
    .i_en        (w_clk_en),
    .i_clr       (w_clk_clr),
    .i_toggle_en (w_toggle_en),
    .o_tick      (w_tick),
    .o_rise_stb  (w_rise_stb),
    .o_fall_stb  (w_fall_stb),
    .o_sclk      (w_sclk)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_tx_sh_nxt    = r_tx_sh;
    w_rx_sh_nxt    = r_rx_sh;
    w_rx_data_nxt  = r_rx_data;
    w_edge_cnt_nxt = r_edge_cnt;
    w_cs_n_nxt     = r_cs_n;
    w_done_nxt     = 1'b0;

    if (w_rise_stb) begin
      w_rx_sh_nxt    = {r_rx_sh[DATA_W-2:0], w_rx_bit};
      w_edge_cnt_nxt = r_edge_cnt + EW'(1);
    end
    if (w_fall_stb) begin
      w_edge_cnt_nxt = r_edge_cnt + EW'(1);
      if (r_edge_cnt != LAST_FALL) w_tx_sh_nxt = {r_tx_sh[DATA_W-2:0], 1'b0};
    end

    unique case (r_state)
      IDLE: begin
        if (bus.start_send) begin
          w_tx_sh_nxt    = r_count;
          w_rx_sh_nxt    = '0;
          w_edge_cnt_nxt = '0;
          w_cs_n_nxt     = 1'b0;
          w_state_nxt    = SETUP;
        end
      end
      SETUP: begin
        if (w_rise_stb) w_state_nxt = SHIFT;
      end
      SHIFT: begin
        // End of the trailing hold: DONE-state outputs land on entry so
        // cs_n rises exactly with the done pulse.
        if (w_tick && (r_edge_cnt == LAST_EDGE)) begin
          w_cs_n_nxt    = 1'b1;
          w_done_nxt    = 1'b1;
          w_tx_sh_nxt   = '0;
          w_rx_data_nxt = r_rx_sh;
          w_state_nxt   = DONE;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!s_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      r_count    <= '0;
      r_tx_sh    <= '0;
      r_rx_sh    <= '0;
      r_rx_data  <= '0;
      r_edge_cnt <= '0;
      r_cs_n     <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      if (bus.next_count) r_count <= r_count + DATA_W'(1);
      r_tx_sh    <= w_tx_sh_nxt;
      r_rx_sh    <= w_rx_sh_nxt;
      r_rx_data  <= w_rx_data_nxt;
      r_edge_cnt <= w_edge_cnt_nxt;
      r_cs_n     <= w_cs_n_nxt;
      r_done     <= w_done_nxt;
    end
  end

  assign bus.sclk        = w_sclk;
  assign bus.mosi        = r_tx_sh[DATA_W-1];
  assign bus.cs_n        = r_cs_n;
  assign bus.busy        = ~r_cs_n;
  assign bus.done        = r_done;
  assign bus.count_value = r_count;
  assign bus.rx_data     = r_rx_data;

endmodule

// File: tb/tb_spi_tx_ctrl.sv
// Scoreboard bench for spi_tx_ctrl: expected frames queued at start_send,
// checked against captured MOSI/rx_data when done pulses.
module tb_spi_tx_ctrl;
  import spi_pkg::*;

  localparam int DATA_W    = SPI_DATA_W;
  localparam int CLK_DIV   = SPI_CLK_DIV;
  localparam int FRAME_LEN = CLK_DIV * (2*DATA_W + 1);

  typedef struct packed {
    logic [DATA_W-1:0] tx;
    logic [DATA_W-1:0] rx;
  } sb_item_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_tx_ctrl_if #(.DATA_W(DATA_W)) ifc ();

  spi_tx_ctrl #(
    .DATA_W  (DATA_W),
    .CLK_DIV (CLK_DIV)
  ) dut (
    .clk     (clk),
    .s_rst_n (rst_n),
    .bus     (ifc)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  sb_item_t          sb_q[$];
  sb_item_t          e;
  logic [DATA_W-1:0] exp_count  = '0;
  logic [DATA_W-1:0] slave_byte = '0;
  logic [DATA_W-1:0] sl_sh      = '0;
  logic [DATA_W-1:0] cap        = '0;
  logic              prev_sclk  = 1'b0;
  logic              prev_cs    = 1'b1;
  int len = 0, rises = 0, n_done = 0, n_start = 0, exp_starts = 0;
  int busy_err = 0, done_err = 0;

  // Monitor and slave model, sampled on the falling clk edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      len = 0; rises = 0; prev_sclk = 1'b0; prev_cs = 1'b1;
      ifc.miso = 1'b0;
    end else begin
      if (ifc.busy !== ~ifc.cs_n) busy_err++;
      if (ifc.done !== (prev_cs === 1'b0 && ifc.cs_n === 1'b1)) done_err++;
      if (prev_cs && !ifc.cs_n) begin
        n_start++; len = 0; rises = 0;
        ifc.miso = slave_byte[DATA_W-1];
        sl_sh    = slave_byte << 1;
      end else if (prev_sclk && !ifc.sclk) begin
        ifc.miso = sl_sh[DATA_W-1];
        sl_sh    = sl_sh << 1;
      end
      if (!prev_sclk && ifc.sclk) begin
        cap = {cap[DATA_W-2:0], ifc.mosi};
        rises++;
      end
      if (!ifc.cs_n) len++;
      if (ifc.done) begin
        n_done++;
        check_eq("sb_depth", sb_q.size(), 1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check_eq("mosi_frame", 32'(cap), 32'(e.tx));
          check_eq("rx_data", 32'(ifc.rx_data), 32'(e.rx));
          check_eq("cs_low_len", len, FRAME_LEN);
          check_eq("sclk_rises", rises, DATA_W);
        end
      end
      prev_sclk = ifc.sclk;
      prev_cs   = ifc.cs_n;
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) begin
      ifc.next_count = 1'($urandom);
      ifc.start_send = 1'($urandom);
      cyc();
    end
    ifc.next_count = 1'b0;
    ifc.start_send = 1'b0;
    @(negedge clk);
    sb_q.delete();
    exp_count = '0;
    check_eq("rst_sclk",  32'(ifc.sclk), 0);
    check_eq("rst_mosi",  32'(ifc.mosi), 0);
    check_eq("rst_cs_n",  32'(ifc.cs_n), 1);
    check_eq("rst_busy",  32'(ifc.busy), 0);
    check_eq("rst_done",  32'(ifc.done), 0);
    check_eq("rst_count", 32'(ifc.count_value), 0);
    check_eq("rst_rx",    32'(ifc.rx_data), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic pulse_next(input int n);
    repeat (n) begin
      ifc.next_count = 1'b1;
      cyc();
      ifc.next_count = 1'b0;
      exp_count++;
    end
  endtask

  task automatic send(input logic [DATA_W-1:0] sbyte, input logic with_next);
    sb_item_t it;
    slave_byte = sbyte;
    it.tx = exp_count;
`ifdef SPI_LOOPBACK_EN
    it.rx = exp_count;
`else
    it.rx = sbyte;
`endif
    sb_q.push_back(it);
    exp_starts++;
    ifc.start_send = 1'b1;
    ifc.next_count = with_next;
    cyc();
    ifc.start_send = 1'b0;
    ifc.next_count = 1'b0;
    if (with_next) exp_count++;
  endtask

  task automatic wait_frames(input int target);
    int t = 0;
    while (n_done < target && t < 4*FRAME_LEN) begin
      @(negedge clk);
      t++;
    end
    check_eq("frame_seen", n_done, target);
  endtask

  initial begin
    ifc.next_count = 1'b0;
    ifc.start_send = 1'b0;

    do_reset(3);

    pulse_next(3);
    @(negedge clk);
    check_eq("count_3", 32'(ifc.count_value), 3);
    send(8'hA5, 1'b0);
    wait_frames(1);

    pulse_next(8'h3C - 8'h03);
    send(8'h5A, 1'b0);
    wait_frames(2);

    // Strobes during a frame: start ignored, count still advances.
    do_reset(2);
    pulse_next(3);
    send(8'hC3, 1'b0);
    repeat (19) cyc();
    ifc.start_send = 1'b1;
    cyc();
    ifc.start_send = 1'b0;
    repeat (4) cyc();
    pulse_next(1);
    wait_frames(3);
    repeat (2*FRAME_LEN) cyc();
    check_eq("no_second_frame", n_start, exp_starts);
    check_eq("count_in_frame", 32'(ifc.count_value), 32'(exp_count));

    do_reset(1);
    pulse_next(255);
    @(negedge clk);
    check_eq("count_ff", 32'(ifc.count_value), 32'hFF);
    pulse_next(1);
    @(negedge clk);
    check_eq("count_wrap", 32'(ifc.count_value), 0);
    pulse_next(127);
    send(8'h96, 1'b1);
    wait_frames(4);
    check_eq("count_after_sim", 32'(ifc.count_value), 32'h80);

    // Abort mid-frame, then a clean frame.
    do_reset(1);
    send(8'h3E, 1'b0);
    repeat (29) cyc();
    do_reset(1);
    repeat (2*FRAME_LEN) cyc();
    check_eq("no_done_on_abort", n_done, 4);
    send(8'h81, 1'b0);
    wait_frames(5);

    check_eq("busy_eq_not_cs", busy_err, 0);
    check_eq("done_at_cs_rise", done_err, 0);
    check_eq("start_count", n_start, exp_starts);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
